ptw_dram_arbiter: RTL and testbench

- Sits directly downstream of the MMU page walker and the CPU load/store/fetch path, and upstream of the DRAM controller.
- Serialises PTE reads, PTE A/D write-backs and ordinary CPU accesses onto the single DRAM request/busy port.
- Presents each requester with a busy/done/rdata view, and captures requests that arrive while DRAM is occupied.
- Page-walk traffic has strict priority, because the CPU is stalled behind a walk anyway.

---
 rtl/ptw_dram_arbiter_pkg.sv | 25 ++
 rtl/ptw_req_slot.sv | 64 ++++++
 rtl/ptw_dram_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ptw_dram_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_dram_arbiter_pkg.sv
// Shared encodings for the page-walk / CPU DRAM arbiter.
//   state_e : arbiter FSM states
//   owner_e : which requester currently owns the DRAM port
//   timeout_cnt_w : width of the WAIT-cycle counter for a given timeout
package ptw_dram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_MMU  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    // Counter must be able to hold the value TIMEOUT_CYCLES itself.
    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/ptw_req_slot.sv
// One-deep request latch for a single requester.
//   clk, rst_n : clock, async active-low reset
//   req_i/we_i/addr_i/wdata_i : request pulse and payload
//   active_i   : this requester currently owns the DRAM port
//   clr_i      : arbiter has taken the slot contents
//   valid_o/we_o/addr_o/wdata_o : latched request
//   busy_c     : slot valid or transaction in flight (combinational)
//   err_o      : one-cycle pulse when a req arrives while busy
module ptw_req_slot #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              active_i,
    input  logic              clr_i,
    output logic              valid_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              busy_c,
    output logic              err_o
);

    logic              valid_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    assign busy_c = valid_q | active_i;

    // A request is only accepted while the requester is idle; otherwise it is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= req_i & busy_c;
            if (clr_i) begin
                valid_q <= 1'b0;
            end else if (req_i && !busy_c) begin
                valid_q <= 1'b1;
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ptw_dram_arbiter.sv
// Serialises MMU page-walk traffic and CPU accesses onto one DRAM port.
// MMU has strict priority; no pre-emption of an in-flight transaction.
//   CLK, RST_X          : clock, async active-low reset
//   mmu_* / cpu_*       : requester groups (req/we/addr/wdata in, busy/done/rdata out)
//   dram_*              : controller port (req held until accepted on dram_busy=0)
//   err_timeout/err_proto : sticky error flags, cleared only by reset
module ptw_dram_arbiter
    import ptw_dram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              mmu_req,
    input  logic              mmu_we,
    input  logic [ADDR_W-1:0] mmu_addr,
    input  logic [DATA_W-1:0] mmu_wdata,
    output logic              mmu_busy,
    output logic              mmu_done,
    output logic [DATA_W-1:0] mmu_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dram_req,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic              dram_busy,
    input  logic [DATA_W-1:0] dram_rdata,
    output logic              err_timeout,
    output logic              err_proto
);

    localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              dram_req_q, dram_req_d;
    logic              dram_we_q, dram_we_d;
    logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
    logic [DATA_W-1:0] dram_wdata_q, dram_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mmu_rdata_q, mmu_rdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              mmu_done_q, mmu_done_d;
    logic              cpu_done_q, cpu_done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_proto_q, err_proto_d;

    logic              mmu_valid, mmu_s_we, mmu_clr, mmu_err;
    logic [ADDR_W-1:0] mmu_s_addr;
    logic [DATA_W-1:0] mmu_s_wdata;
    logic              cpu_valid, cpu_s_we, cpu_clr, cpu_err;
    logic [ADDR_W-1:0] cpu_s_addr;
    logic [DATA_W-1:0] cpu_s_wdata;

    ptw_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mmu_slot (
        .clk      (CLK),
        .rst_n    (RST_X),
        .req_i    (mmu_req),
        .we_i     (mmu_we),
        .addr_i   (mmu_addr),
        .wdata_i  (mmu_wdata),
        .active_i (owner_q == OWN_MMU),
        .clr_i    (mmu_clr),
        .valid_o  (mmu_valid),
        .we_o     (mmu_s_we),
        .addr_o   (mmu_s_addr),
        .wdata_o  (mmu_s_wdata),
        .busy_c   (mmu_busy),
        .err_o    (mmu_err)
    );

    ptw_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_slot (
        .clk      (CLK),
        .rst_n    (RST_X),
        .req_i    (cpu_req),
        .we_i     (cpu_we),
        .addr_i   (cpu_addr),
        .wdata_i  (cpu_wdata),
        .active_i (owner_q == OWN_CPU),
        .clr_i    (cpu_clr),
        .valid_o  (cpu_valid),
        .we_o     (cpu_s_we),
        .addr_o   (cpu_s_addr),
        .wdata_o  (cpu_s_wdata),
        .busy_c   (cpu_busy),
        .err_o    (cpu_err)
    );

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            dram_req_q    <= 1'b0;
            dram_we_q     <= 1'b0;
            dram_addr_q   <= '0;
            dram_wdata_q  <= '0;
            cnt_q         <= '0;
            mmu_rdata_q   <= '0;
            cpu_rdata_q   <= '0;
            mmu_done_q    <= 1'b0;
            cpu_done_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            dram_req_q    <= dram_req_d;
            dram_we_q     <= dram_we_d;
            dram_addr_q   <= dram_addr_d;
            dram_wdata_q  <= dram_wdata_d;
            cnt_q         <= cnt_d;
            mmu_rdata_q   <= mmu_rdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            mmu_done_q    <= mmu_done_d;
            cpu_done_q    <= cpu_done_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
        end
    end

    // Next-state and next-output logic; done/rdata are set on the WAIT->RESP transition.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        dram_req_d    = dram_req_q;
        dram_we_d     = dram_we_q;
        dram_addr_d   = dram_addr_q;
        dram_wdata_d  = dram_wdata_q;
        cnt_d         = cnt_q;
        mmu_rdata_d   = mmu_rdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        mmu_done_d    = 1'b0;
        cpu_done_d    = 1'b0;
        err_timeout_d = err_timeout_q;
        err_proto_d   = err_proto_q | mmu_err | cpu_err;
        mmu_clr       = 1'b0;
        cpu_clr       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mmu_valid) begin
                    owner_d      = OWN_MMU;
                    dram_we_d    = mmu_s_we;
                    dram_addr_d  = mmu_s_addr;
                    dram_wdata_d = mmu_s_wdata;
                    dram_req_d   = 1'b1;
                    mmu_clr      = 1'b1;
                    state_d      = ST_ISSUE;
                end else if (cpu_valid) begin
                    owner_d      = OWN_CPU;
                    dram_we_d    = cpu_s_we;
                    dram_addr_d  = cpu_s_addr;
                    dram_wdata_d = cpu_s_wdata;
                    dram_req_d   = 1'b1;
                    cpu_clr      = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!dram_busy) begin
                    dram_req_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!dram_busy) begin
                    if (!dram_we_q) begin
                        if (owner_q == OWN_MMU) mmu_rdata_d = dram_rdata;
                        if (owner_q == OWN_CPU) cpu_rdata_d = dram_rdata;
                    end
                    mmu_done_d = (owner_q == OWN_MMU);
                    cpu_done_d = (owner_q == OWN_CPU);
                    state_d    = ST_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_timeout_d = 1'b1;
                    if (owner_q == OWN_MMU) mmu_rdata_d = '0;
                    if (owner_q == OWN_CPU) cpu_rdata_d = '0;
                    mmu_done_d = (owner_q == OWN_MMU);
                    cpu_done_d = (owner_q == OWN_CPU);
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                owner_d    = OWN_NONE;
                dram_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    assign dram_req    = dram_req_q;
    assign dram_we     = dram_we_q;
    assign dram_addr   = dram_addr_q;
    assign dram_wdata  = dram_wdata_q;
    assign mmu_done    = mmu_done_q;
    assign cpu_done    = cpu_done_q;
    assign mmu_rdata   = mmu_rdata_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign err_timeout = err_timeout_q;
    assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_ptw_dram_arbiter.sv
// Scoreboard bench for ptw_dram_arbiter: directed requests push expected DRAM
// transactions and expected completions; a DRAM model and done monitors pop and compare.
module tb_ptw_dram_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b1;
    logic          mmu_req = 1'b0, mmu_we = 1'b0;
    logic [AW-1:0] mmu_addr = '0;
    logic [DW-1:0] mmu_wdata = '0;
    logic          mmu_busy, mmu_done;
    logic [DW-1:0] mmu_rdata;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_done;
    logic [DW-1:0] cpu_rdata;
    logic          dram_req, dram_we;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic          dram_busy = 1'b0;
    logic [DW-1:0] dram_rdata = '0;
    logic          err_timeout, err_proto;

    ptw_dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_X(RST_X),
        .mmu_req(mmu_req), .mmu_we(mmu_we), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
        .mmu_busy(mmu_busy), .mmu_done(mmu_done), .mmu_rdata(mmu_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .dram_busy(dram_busy), .dram_rdata(dram_rdata),
        .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } dtx_t;

    dtx_t          dram_q[$];
    logic [DW-1:0] mmu_q[$];
    logic [DW-1:0] cpu_q[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int req_cyc = 0;
    int mmu_done_n = 0, cpu_done_n = 0, dram_acc_n = 0;
    int mmu_done_cyc = 0, cpu_done_cyc = 0;
    int lat = 2;
    bit stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // DRAM controller model: accepts on req && !busy, busy for lat cycles (or forever when stuck).
    initial begin
        logic          acc;
        int            cnt;
        logic [DW-1:0] cur_rdata;
        dtx_t          t;
        cnt = 0;
        cur_rdata = '0;
        forever begin
            @(negedge CLK);
            acc = RST_X && dram_req && !dram_busy;
            @(posedge CLK);
            #1;
            if (!RST_X) begin
                dram_busy = 1'b0;
                cnt = 0;
            end else if (acc) begin
                dram_acc_n++;
                if (dram_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dram_unexpected: got addr 0x%08h expected no transaction", dram_addr);
                end else begin
                    t = dram_q.pop_front();
                    check("dram_we", 32'(dram_we), 32'(t.we));
                    check("dram_addr", dram_addr, t.addr);
                    check("dram_wdata", dram_wdata, t.wdata);
                    cur_rdata = t.rdata;
                end
                dram_busy = 1'b1;
                cnt = lat;
            end else if (dram_busy && !stuck) begin
                cnt--;
                if (cnt <= 0) begin
                    dram_busy = 1'b0;
                    dram_rdata = cur_rdata;
                end
            end
        end
    end

    // Completion monitor: every done pulse pops one expected rdata.
    initial forever begin
        @(negedge CLK);
        if (RST_X) begin
            if (mmu_done) begin
                mmu_done_n++;
                mmu_done_cyc = cyc;
                if (mmu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mmu_done_unexpected: got pulse expected none");
                end else check("mmu_rdata", mmu_rdata, mmu_q.pop_front());
            end
            if (cpu_done) begin
                cpu_done_n++;
                cpu_done_cyc = cyc;
                if (cpu_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cpu_done_unexpected: got pulse expected none");
                end else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
        end
    end

    task automatic drive(input bit m, input bit mwe, input logic [31:0] ma, input logic [31:0] md,
                         input bit c, input bit cwe, input logic [31:0] ca, input logic [31:0] cd);
        @(negedge CLK);
        if (m) begin mmu_req = 1'b1; mmu_we = mwe; mmu_addr = ma; mmu_wdata = md; end
        if (c) begin cpu_req = 1'b1; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd; end
        req_cyc = cyc;
        @(negedge CLK);
        mmu_req = 1'b0;
        cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input bit is_cpu, input int target);
        int k;
        k = 0;
        while (((is_cpu ? cpu_done_n : mmu_done_n) < target) && k < 200) begin
            @(negedge CLK);
            k++;
        end
        @(negedge CLK);
        check({name, "_wait"}, 32'(is_cpu ? cpu_done_n : mmu_done_n), 32'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        int base_acc, base_cpu, k;
        #1 RST_X = 1'b0;
        #11;
        check("rst_dram_req", 32'(dram_req), 0);
        check("rst_mmu_busy", 32'(mmu_busy), 0);
        check("rst_cpu_busy", 32'(cpu_busy), 0);
        check("rst_done", 32'({mmu_done, cpu_done}), 0);
        check("rst_errs", 32'({err_timeout, err_proto}), 0);
        check("rst_rdata", mmu_rdata | cpu_rdata, 0);
        check("rst_dram_addr", dram_addr, 0);
        @(negedge CLK);
        RST_X = 1'b1;
        idle(2);

        // MMU read, controller busy 2 cycles
        lat = 2;
        dram_q.push_back('{1'b0, 32'h8000_1004, 32'h0, 32'h2000_0C01});
        mmu_q.push_back(32'h2000_0C01);
        drive(1, 0, 32'h8000_1004, 0, 0, 0, 0, 0);
        wait_done("t1_mmu", 0, 1);
        idle(2);
        check("t1_cpu_rdata", cpu_rdata, 0);
        check("t1_cpu_done_n", 32'(cpu_done_n), 0);
        check("t1_busy_clear", 32'({mmu_busy, cpu_busy}), 0);
        check("t1_dram_acc", 32'(dram_acc_n), 1);

        // Simultaneous MMU write-back and CPU read: MMU first
        dram_q.push_back('{1'b1, 32'h8000_1004, 32'h0000_00CF, 32'hDEAD_BEEF});
        dram_q.push_back('{1'b0, 32'h0040_0000, 32'h0, 32'h0BAD_F00D});
        mmu_q.push_back(32'h2000_0C01);
        cpu_q.push_back(32'h0BAD_F00D);
        drive(1, 1, 32'h8000_1004, 32'h0000_00CF, 1, 0, 32'h0040_0000, 0);
        wait_done("t2_mmu", 0, 2);
        wait_done("t2_cpu", 1, 1);
        check("t2_gap_ge3", 32'((cpu_done_cyc - mmu_done_cyc) >= 3), 1);
        check("t2_dram_acc", 32'(dram_acc_n), 3);

        // Minimum latency, busy exactly 1 cycle
        lat = 1;
        dram_q.push_back('{1'b0, 32'h0000_1000, 32'h0, 32'h1111_2222});
        cpu_q.push_back(32'h1111_2222);
        drive(0, 0, 0, 0, 1, 0, 32'h0000_1000, 0);
        wait_done("t3_cpu", 1, 2);
        check("t3_cpu_latency", 32'(cpu_done_cyc - req_cyc), 5);
        dram_q.push_back('{1'b0, 32'h0000_2000, 32'h0, 32'h3333_4444});
        mmu_q.push_back(32'h3333_4444);
        drive(1, 0, 32'h0000_2000, 0, 0, 0, 0, 0);
        wait_done("t3_mmu", 0, 3);
        check("t3_mmu_latency", 32'(mmu_done_cyc - req_cyc), 5);

        // Timeout: busy stuck high, 8 WAIT cycles then RESP
        check("t4_err_timeout_pre", 32'(err_timeout), 0);
        stuck = 1'b1;
        dram_q.push_back('{1'b0, 32'h0050_0000, 32'h0, 32'h5555_6666});
        cpu_q.push_back(32'h0);
        drive(0, 0, 0, 0, 1, 0, 32'h0050_0000, 0);
        wait_done("t4_cpu", 1, 3);
        check("t4_timeout_latency", 32'(cpu_done_cyc - req_cyc), 11);
        check("t4_err_timeout", 32'(err_timeout), 1);
        stuck = 1'b0;
        dram_q.push_back('{1'b0, 32'h0060_0000, 32'h0, 32'h7777_8888});
        mmu_q.push_back(32'h7777_8888);
        drive(1, 0, 32'h0060_0000, 0, 0, 0, 0, 0);
        wait_done("t4_after", 0, 4);
        check("t4_err_timeout_sticky", 32'(err_timeout), 1);

        // Protocol error: CPU re-requests while busy
        check("t5_err_proto_pre", 32'(err_proto), 0);
        lat = 3;
        base_acc = dram_acc_n;
        base_cpu = cpu_done_n;
        dram_q.push_back('{1'b0, 32'h0070_0000, 32'h0, 32'h9999_AAAA});
        cpu_q.push_back(32'h9999_AAAA);
        drive(0, 0, 0, 0, 1, 0, 32'h0070_0000, 0);
        check("t5_cpu_busy", 32'(cpu_busy), 1);
        drive(0, 0, 0, 0, 1, 0, 32'h0080_0000, 0);
        drive(0, 0, 0, 0, 1, 1, 32'h0090_0000, 32'h1);
        wait_done("t5_cpu", 1, base_cpu + 1);
        idle(6);
        check("t5_err_proto", 32'(err_proto), 1);
        check("t5_one_dram_tx", 32'(dram_acc_n - base_acc), 1);
        check("t5_one_done", 32'(cpu_done_n - base_cpu), 1);

        // Reset during WAIT: abandoned, no done afterwards
        stuck = 1'b1;
        base_acc = dram_acc_n;
        dram_q.push_back('{1'b1, 32'h8000_2000, 32'h0000_00A5, 32'h0});
        drive(1, 1, 32'h8000_2000, 32'h0000_00A5, 0, 0, 0, 0);
        k = 0;
        while (dram_acc_n == base_acc && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("t6_reached_wait", 32'(dram_acc_n - base_acc), 1);
        @(negedge CLK);
        #2 RST_X = 1'b0;
        #1;
        check("t6_dram_req", 32'(dram_req), 0);
        check("t6_busies", 32'({mmu_busy, cpu_busy}), 0);
        check("t6_done", 32'({mmu_done, cpu_done}), 0);
        check("t6_errs", 32'({err_timeout, err_proto}), 0);
        stuck = 1'b0;
        @(negedge CLK);
        RST_X = 1'b1;
        idle(12);
        check("t6_no_mmu_done", 32'(mmu_done_n), 4);
        lat = 1;
        dram_q.push_back('{1'b0, 32'h0090_0000, 32'h0, 32'hCAFE_F00D});
        cpu_q.push_back(32'hCAFE_F00D);
        drive(0, 0, 0, 0, 1, 0, 32'h0090_0000, 0);
        wait_done("t6_restart", 1, cpu_done_n + 1);
        check("t6_restart_latency", 32'(cpu_done_cyc - req_cyc), 5);
        idle(4);

        check("end_dram_q_empty", 32'(dram_q.size()), 0);
        check("end_mmu_q_empty", 32'(mmu_q.size()), 0);
        check("end_cpu_q_empty", 32'(cpu_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
